// File: rtl/tx_payload_buffer.sv
// Packet FIFO feeding the Ethernet TX encapsulator: reserves a 2-byte length header per packet,
// back-fills it when the packet ends, then publishes the packet for show-ahead reading.
module tx_payload_buffer #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned MAX_PAYLOAD = 1500
) (
    input  logic       eth_tx_clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       wr_last,
    output logic       wr_ready,
    output logic       wr_drop,
    output logic [7:0] rd_data,
    input  logic       rd_en,
    input  logic       pkt_txed,
    output logic [1:0] pkt_ready
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PW    = ADDR_W + 1;
    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {W_IDLE, W_DATA, W_DROP, W_LEN_HI, W_LEN_LO} wr_state_t;

    wr_state_t         wr_state, wr_state_nxt;
    logic [PW-1:0]     pkt_start, wr_cur, commit_ptr, rd_ptr;
    logic [LEN_W-1:0]  len_cnt;
    logic [7:0]        mem [DEPTH];

    logic [PW-1:0]     used, free;
    logic              accept, oversize, commit, txed_dec;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign used     = wr_cur - rd_ptr;
    assign free     = PW'(DEPTH) - used;
    assign accept   = wr_en && wr_ready;
    assign oversize = (len_cnt >= LEN_W'(MAX_PAYLOAD));
    assign commit   = (wr_state == W_LEN_LO);
    assign txed_dec = pkt_txed && (pkt_ready != 2'd0);

    // State register
    always_ff @(posedge eth_tx_clk) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_state_nxt;
    end

    // Next-state logic
    always_comb begin
        wr_state_nxt = wr_state;
        unique case (wr_state)
            W_IDLE:   if (accept) wr_state_nxt = wr_last ? W_LEN_HI : W_DATA;
            W_DATA: begin
                if (accept) begin
                    if (oversize)     wr_state_nxt = wr_last ? W_IDLE : W_DROP;
                    else if (wr_last) wr_state_nxt = W_LEN_HI;
                end
            end
            W_DROP:   if (accept && wr_last) wr_state_nxt = W_IDLE;
            W_LEN_HI: wr_state_nxt = W_LEN_LO;
            W_LEN_LO: wr_state_nxt = W_IDLE;
            default:  wr_state_nxt = W_IDLE;
        endcase
    end

    // Outputs: ready and the single memory write port (payload bytes and header back-fill)
    always_comb begin
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 8'h00;
        unique case (wr_state)
            W_IDLE: begin
                wr_ready = (pkt_ready < 2'd3) && (free >= PW'(3));
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = ADDR_W'(pkt_start + PW'(2));
                    mem_wdata = wr_data;
                end
            end
            W_DATA: begin
                wr_ready = (free >= PW'(1));
                if (accept && !oversize) begin
                    mem_we    = 1'b1;
                    mem_waddr = ADDR_W'(wr_cur);
                    mem_wdata = wr_data;
                end
            end
            W_DROP:   wr_ready = 1'b1;
            W_LEN_HI: begin
                mem_we    = 1'b1;
                mem_waddr = ADDR_W'(pkt_start);
                mem_wdata = reflect8(len_cnt[15:8]);
            end
            W_LEN_LO: begin
                mem_we    = 1'b1;
                mem_waddr = ADDR_W'(pkt_start + PW'(1));
                mem_wdata = reflect8(len_cnt[7:0]);
            end
            default: ;
        endcase
    end

    // Storage is not reset; stale bytes are never visible past commit_ptr
    always_ff @(posedge eth_tx_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Pointers, length counter, drop pulse and ready-packet count
    always_ff @(posedge eth_tx_clk) begin
        if (rst) begin
            pkt_start  <= '0;
            wr_cur     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            len_cnt    <= '0;
            wr_drop    <= 1'b0;
            pkt_ready  <= 2'd0;
        end else begin
            wr_drop <= 1'b0;
            unique case (wr_state)
                W_IDLE: begin
                    if (accept) begin
                        wr_cur  <= pkt_start + PW'(3);
                        len_cnt <= LEN_W'(1);
                    end
                end
                W_DATA: begin
                    if (accept) begin
                        if (oversize) begin
                            wr_cur  <= pkt_start;
                            wr_drop <= 1'b1;
                        end else begin
                            wr_cur  <= wr_cur + PW'(1);
                            len_cnt <= len_cnt + LEN_W'(1);
                        end
                    end
                end
                W_LEN_LO: begin
                    commit_ptr <= wr_cur;
                    pkt_start  <= wr_cur;
                end
                default: ;
            endcase
            if (rd_en && (rd_ptr != commit_ptr)) rd_ptr <= rd_ptr + PW'(1);
            if (commit && !txed_dec)      pkt_ready <= pkt_ready + 2'd1;
            else if (!commit && txed_dec) pkt_ready <= pkt_ready - 2'd1;
        end
    end

    assign rd_data = (rd_ptr != commit_ptr) ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;

endmodule

// File: tb/tb_tx_payload_buffer.sv
// Directed bench for tx_payload_buffer: header back-fill, drops, packet count, wrap and reset.
module tb_tx_payload_buffer;
    logic       eth_tx_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       wr_last = 1'b0;
    logic       wr_ready;
    logic       wr_drop;
    logic [7:0] rd_data;
    logic       rd_en = 1'b0;
    logic       pkt_txed = 1'b0;
    logic [1:0] pkt_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int wptr  = 0;

    tx_payload_buffer dut (
        .eth_tx_clk(eth_tx_clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_last   (wr_last),
        .wr_ready  (wr_ready),
        .wr_drop   (wr_drop),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .pkt_txed  (pkt_txed),
        .pkt_ready (pkt_ready)
    );

    always #5 eth_tx_clk = ~eth_tx_clk;

    task automatic tick();
        @(posedge eth_tx_clk);
        #1;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!wr_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!wr_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_ready_timeout: wr_ready=%0b after %0d cycles, required 1", wr_ready, guard);
        end
    endtask

    // Payload byte i of a packet is base+i; the last byte carries wr_last
    task automatic send_pkt(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            wait_ready();
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            wr_last = (i == len - 1);
            tick();
        end
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wptr    = wptr + len + 2;
    endtask

    task automatic pulse_txed();
        pkt_txed = 1'b1;
        tick();
        pkt_txed = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rd_en = 1'b0;
        pulse_txed();
    endtask

    // Reads header+payload under continuous rd_en; reports mismatch count and first offender
    task automatic read_pkt(input int len, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] base, output int bad, output int first_idx,
                            output logic [7:0] first_got, output logic [7:0] first_exp);
        logic [7:0] exp;
        bad = 0; first_idx = -1; first_got = 8'h00; first_exp = 8'h00;
        rd_en = 1'b1;
        for (int k = 0; k < len + 2; k++) begin
            exp = (k == 0) ? hi : (k == 1) ? lo : base + 8'(k - 2);
            if (rd_data !== exp) begin
                if (bad == 0) begin
                    first_idx = k; first_got = rd_data; first_exp = exp;
                end
                bad++;
            end
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp += 4;
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL reset_pkt_ready: got %0d want 0", pkt_ready); end
        if (wr_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); end
        if (wr_drop !== 1'b0)   begin n_bad++; $display("FAIL reset_wr_drop: got %0b want 0", wr_drop); end
        if (rd_data !== 8'h00)  begin n_bad++; $display("FAIL reset_rd_data: got %02h want 00", rd_data); end
    endtask

    task automatic test_single_pkt();
        int bad, idx;
        logic [7:0] got, exp;
        send_pkt(46, 8'h00);
        n_cmp++;
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL commit_n0: pkt_ready got %0d want 0", pkt_ready); end
        tick();
        n_cmp++;
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL commit_n1: pkt_ready got %0d want 0", pkt_ready); end
        tick();
        n_cmp++;
        if (pkt_ready !== 2'd1) begin n_bad++; $display("FAIL commit_n2: pkt_ready got %0d want 1", pkt_ready); end
        read_pkt(46, 8'h00, 8'h74, 8'h00, bad, idx, got, exp);
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL pkt46_data: %0d bad bytes, first at %0d got %02h want %02h", bad, idx, got, exp); end
        n_cmp++;
        if (rd_data !== 8'h00) begin n_bad++; $display("FAIL pkt46_empty: rd_data got %02h want 00", rd_data); end
        pulse_txed();
        n_cmp++;
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL pkt46_txed: pkt_ready got %0d want 0", pkt_ready); end
    endtask

    task automatic test_oversize();
        int bad, idx;
        logic [7:0] got, exp;
        for (int i = 0; i < 1501; i++) begin
            wait_ready();
            wr_en   = 1'b1;
            wr_data = 8'(i);
            wr_last = (i == 1500);
            tick();
            if (i == 1499) begin
                n_cmp++;
                if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL drop_early: wr_drop got %0b want 0 at byte 1500", wr_drop); end
            end
        end
        wr_en = 1'b0; wr_last = 1'b0;
        n_cmp++;
        if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: wr_drop got %0b want 1", wr_drop); end
        tick();
        n_cmp += 3;
        if (wr_drop !== 1'b0)   begin n_bad++; $display("FAIL drop_width: wr_drop got %0b want 0", wr_drop); end
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL drop_pkt_ready: got %0d want 0", pkt_ready); end
        if (rd_data !== 8'h00)  begin n_bad++; $display("FAIL drop_rd_data: got %02h want 00", rd_data); end
        send_pkt(60, 8'h40);
        tick();
        tick();
        n_cmp++;
        if (pkt_ready !== 2'd1) begin n_bad++; $display("FAIL pkt60_ready: got %0d want 1", pkt_ready); end
        read_pkt(60, 8'h00, 8'h3C, 8'h40, bad, idx, got, exp);
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL pkt60_data: %0d bad bytes, first at %0d got %02h want %02h", bad, idx, got, exp); end
        pulse_txed();
    endtask

    task automatic test_full_count();
        int bad, idx;
        logic [7:0] got, exp;
        send_pkt(10, 8'h10);
        send_pkt(10, 8'h20);
        send_pkt(10, 8'h30);
        tick();
        tick();
        n_cmp += 2;
        if (pkt_ready !== 2'd3) begin n_bad++; $display("FAIL full_pkt_ready: got %0d want 3", pkt_ready); end
        if (wr_ready !== 1'b0)  begin n_bad++; $display("FAIL full_wr_ready: got %0b want 0", wr_ready); end
        pulse_txed();
        n_cmp += 2;
        if (pkt_ready !== 2'd2) begin n_bad++; $display("FAIL txed_pkt_ready: got %0d want 2", pkt_ready); end
        if (wr_ready !== 1'b1)  begin n_bad++; $display("FAIL txed_wr_ready: got %0b want 1", wr_ready); end
        for (int p = 0; p < 3; p++) begin
            read_pkt(10, 8'h00, 8'h50, 8'h10 + 8'(16 * p), bad, idx, got, exp);
            n_cmp++;
            if (bad !== 0) begin n_bad++; $display("FAIL pkt10_%0d_data: %0d bad, first at %0d got %02h want %02h", p, bad, idx, got, exp); end
        end
        pulse_txed();
        n_cmp++;
        if (pkt_ready !== 2'd1) begin n_bad++; $display("FAIL full_drain: pkt_ready got %0d want 1", pkt_ready); end
    endtask

    task automatic test_txed_commit();
        int bad, idx;
        logic [7:0] got, exp;
        send_pkt(10, 8'h70);
        tick();
        pulse_txed();
        n_cmp++;
        if (pkt_ready !== 2'd1) begin n_bad++; $display("FAIL txed_with_commit: pkt_ready got %0d want 1", pkt_ready); end
        read_pkt(10, 8'h00, 8'h50, 8'h70, bad, idx, got, exp);
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL txed_commit_data: %0d bad, first at %0d got %02h want %02h", bad, idx, got, exp); end
        pulse_txed();
    endtask

    task automatic test_wrap_and_reset();
        int bad, idx, remaining, chunk;
        logic [7:0] got, exp;
        remaining = 2040 - wptr;
        for (int guard = 0; guard < 8 && remaining > 0; guard++) begin
            chunk = (remaining > 1002) ? 1002 : remaining;
            send_pkt(chunk - 2, 8'h00);
            tick();
            tick();
            drain(chunk);
            remaining = remaining - chunk;
        end
        n_cmp++;
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL fill_drain: pkt_ready got %0d want 0", pkt_ready); end
        send_pkt(20, 8'hA0);
        tick();
        tick();
        n_cmp++;
        if (pkt_ready !== 2'd1) begin n_bad++; $display("FAIL wrap_ready: got %0d want 1", pkt_ready); end
        read_pkt(20, 8'h00, 8'h28, 8'hA0, bad, idx, got, exp);
        n_cmp += 2;
        if (bad !== 0) begin n_bad++; $display("FAIL wrap_data: %0d bad, first at %0d got %02h want %02h", bad, idx, got, exp); end
        if (rd_data !== 8'h00) begin n_bad++; $display("FAIL wrap_empty: rd_data got %02h want 00", rd_data); end
        // Leave the wrapped packet counted, then start another and reset in its middle
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hE0 + 8'(i); wr_last = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp += 4;
        if (pkt_ready !== 2'd0) begin n_bad++; $display("FAIL midrst_pkt_ready: got %0d want 0", pkt_ready); end
        if (rd_data !== 8'h00)  begin n_bad++; $display("FAIL midrst_rd_data: got %02h want 00", rd_data); end
        if (wr_ready !== 1'b1)  begin n_bad++; $display("FAIL midrst_wr_ready: got %0b want 1", wr_ready); end
        if (wr_drop !== 1'b0)   begin n_bad++; $display("FAIL midrst_wr_drop: got %0b want 0", wr_drop); end
        send_pkt(4, 8'hC0);
        tick();
        tick();
        n_cmp++;
        if (pkt_ready !== 2'd1) begin n_bad++; $display("FAIL post_rst_ready: got %0d want 1", pkt_ready); end
        read_pkt(4, 8'h00, 8'h20, 8'hC0, bad, idx, got, exp);
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL post_rst_data: %0d bad, first at %0d got %02h want %02h", bad, idx, got, exp); end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_oversize();
        test_full_count();
        test_txed_commit();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
